// File: rtl/reg_bank_wb.sv
// Eight-entry 16-bit register bank with a one-deep write-back buffer, read bypass
// and per-register pending-write (busy) flags. Register 0 always reads zero.
module reg_bank_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        wb_hold,
    input  logic        set_busy,
    input  logic [2:0]  set_addr,
    output logic [7:0]  busy,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7,
    input  logic [2:0]  rd_sel_a,
    input  logic [2:0]  rd_sel_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b
);

    logic [15:0] r_regs [8];
    logic        r_buf_valid;
    logic [2:0]  r_buf_addr;
    logic [15:0] r_buf_data;
    logic [7:0]  r_busy;

    logic        w_commit;
    logic        w_accept;
    logic [7:0]  w_busy_d;

    assign w_commit = r_buf_valid & ~wb_hold;
    assign wb_ready = ~rst & (~r_buf_valid | ~wb_hold);
    assign w_accept = wb_valid & wb_ready;

    // Clear on commit first, then apply set so a same-edge set wins.
    always_comb begin
        w_busy_d = r_busy;
        if (w_commit) begin
            w_busy_d[r_buf_addr] = 1'b0;
        end
        if (set_busy && (set_addr != 3'd0)) begin
            w_busy_d[set_addr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 3'd0;
            r_buf_data  <= 16'h0000;
            r_busy      <= 8'h00;
        end else begin
            if (w_commit && (r_buf_addr != 3'd0)) begin
                r_regs[r_buf_addr] <= r_buf_data;
            end
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= wb_addr;
                r_buf_data  <= wb_data;
            end else if (w_commit) begin
                r_buf_valid <= 1'b0;
            end
            r_busy <= w_busy_d;
        end
    end

    // Buffered data forwards to readers even while the commit is held off.
    always_comb begin
        if (r_buf_valid && (r_buf_addr == rd_sel_a) && (rd_sel_a != 3'd0)) begin
            rd_data_a = r_buf_data;
        end else begin
            rd_data_a = r_regs[rd_sel_a];
        end
        if (r_buf_valid && (r_buf_addr == rd_sel_b) && (rd_sel_b != 3'd0)) begin
            rd_data_b = r_buf_data;
        end else begin
            rd_data_b = r_regs[rd_sel_b];
        end
    end

    assign busy = r_busy;
    assign r0   = r_regs[0];
    assign r1   = r_regs[1];
    assign r2   = r_regs[2];
    assign r3   = r_regs[3];
    assign r4   = r_regs[4];
    assign r5   = r_regs[5];
    assign r6   = r_regs[6];
    assign r7   = r_regs[7];

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed self-checking bench for reg_bank_wb: reset, write latency, hold,
// back-to-back writes, register-0 behaviour and busy set/clear collision.
module tb_reg_bank_wb;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_hold;
    logic        set_busy;
    logic [2:0]  set_addr;
    logic [7:0]  busy;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [2:0]  rd_sel_a;
    logic [2:0]  rd_sel_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;

    int n_checks;
    int n_pass;

    reg_bank_wb dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_hold   (wb_hold),
        .set_busy  (set_busy),
        .set_addr  (set_addr),
        .busy      (busy),
        .r0        (r0),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .r4        (r4),
        .r5        (r5),
        .r6        (r6),
        .r7        (r7),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = 3'd0;
        wb_data  = 16'h0000;
        wb_hold  = 1'b0;
        set_busy = 1'b0;
        set_addr = 3'd0;
        rd_sel_a = 3'd0;
        rd_sel_b = 3'd0;
        #1;
        check("ready_in_rst", {15'd0, wb_ready}, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", {15'd0, wb_ready}, 16'h0001);
        check("r3_init", r3, 16'h0000);
        check("r7_init", r7, 16'h0000);
        check("busy_init", {8'd0, busy}, 16'h0000);

        // Reset clears a written register
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        tick();
        wb_valid = 1'b0;
        tick();
        check("r3_written", r3, 16'h1234);
        rst = 1'b1;
        #1;
        check("ready_rst_hi", {15'd0, wb_ready}, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        check("r3_after_rst", r3, 16'h0000);
        check("busy_after_rst", {8'd0, busy}, 16'h0000);
        check("ready_post_rst", {15'd0, wb_ready}, 16'h0001);

        // Basic write with busy tracking
        set_busy = 1'b1; set_addr = 3'd5;
        tick();
        set_busy = 1'b0;
        check("busy5_set", {8'd0, busy}, 16'h0020);
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF; rd_sel_a = 3'd5;
        tick();
        wb_valid = 1'b0;
        #1;
        check("byp5_n1", rd_data_a, 16'hBEEF);
        check("r5_n1", r5, 16'h0000);
        check("busy5_n1", {8'd0, busy}, 16'h0020);
        tick();
        check("r5_n2", r5, 16'hBEEF);
        check("busy5_n2", {8'd0, busy}, 16'h0000);

        // Hold keeps the buffer and ignores new data
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA; rd_sel_b = 3'd2;
        tick();
        wb_hold = 1'b1; wb_data = 16'h00BB;
        #1;
        check("hold_ready0", {15'd0, wb_ready}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ready", {15'd0, wb_ready}, 16'h0000);
            check("hold_r2", r2, 16'h0000);
            check("hold_byp", rd_data_b, 16'h00AA);
        end
        wb_hold = 1'b0;
        #1;
        check("unhold_ready", {15'd0, wb_ready}, 16'h0001);
        tick();
        wb_valid = 1'b0;
        check("unhold_r2", r2, 16'h00AA);
        check("unhold_byp", rd_data_b, 16'h00BB);
        tick();
        check("bb_r2", r2, 16'h00BB);

        // Back-to-back writes
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h0011;
        #1;
        check("b2b_ready1", {15'd0, wb_ready}, 16'h0001);
        tick();
        wb_addr = 3'd2; wb_data = 16'h0022;
        check("b2b_ready2", {15'd0, wb_ready}, 16'h0001);
        tick();
        wb_addr = 3'd3; wb_data = 16'h0033;
        check("b2b_ready3", {15'd0, wb_ready}, 16'h0001);
        tick();
        wb_valid = 1'b0;
        tick();
        check("b2b_r1", r1, 16'h0011);
        check("b2b_r2", r2, 16'h0022);
        check("b2b_r3", r3, 16'h0033);

        // Register 0 is hardwired
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        set_busy = 1'b1; set_addr = 3'd0; rd_sel_a = 3'd0;
        tick();
        wb_valid = 1'b0; set_busy = 1'b0;
        check("r0_busy", {8'd0, busy}, 16'h0000);
        check("r0_byp", rd_data_a, 16'h0000);
        tick();
        check("r0_val", r0, 16'h0000);
        check("r0_ready", {15'd0, wb_ready}, 16'h0001);

        // Set wins over same-edge commit clear
        set_busy = 1'b1; set_addr = 3'd4;
        tick();
        set_busy = 1'b0;
        check("busy4_set", {8'd0, busy}, 16'h0010);
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
        tick();
        wb_valid = 1'b0;
        set_busy = 1'b1; set_addr = 3'd4;
        tick();
        set_busy = 1'b0;
        check("coll_busy4", {8'd0, busy}, 16'h0010);
        check("coll_r4", r4, 16'h4444);

        // Reset discards a buffered write
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666; rd_sel_a = 3'd6;
        tick();
        wb_valid = 1'b0;
        check("pre_rst_byp6", rd_data_a, 16'h6666);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("disc_r6", r6, 16'h0000);
        check("disc_byp6", rd_data_a, 16'h0000);
        check("disc_r4", r4, 16'h0000);
        check("disc_busy", {8'd0, busy}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_wb.md
REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 SHALL have parameter: none; data width fixed at 16 bits, depth fixed at 8 registers, address 3 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: wb_valid  input  1  write-back request present.
REQ-005 SHALL have port: wb_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: wb_addr  input  3  destination register index.
REQ-007 SHALL have port: wb_data  input  16  value to write.
REQ-008 SHALL have port: wb_hold  input  1  suppresses commit of buffered write this cycle.
REQ-009 SHALL have port: set_busy  input  1  marks a register as pending write (issue side).
REQ-010 SHALL have port: set_addr  input  3  register index for set_busy.
REQ-011 SHALL have port: busy  output  8  per-register pending-write flags.
REQ-012 SHALL have ports: r0..r7  output  16 each  register contents, wired to A0..A7 of the downstream 8:1 16-bit select mux.
REQ-013 SHALL have ports: rd_sel_a, rd_sel_b  input  3  read selects; rd_data_a, rd_data_b  output  16  bypassed read data.

Function
REQ-014 SHALL hold a one-entry write-back buffer (buf_valid, buf_addr, buf_data).
REQ-015 SHALL define commit = buf_valid AND NOT wb_hold; on commit, register[buf_addr] takes buf_data at the clock edge.
REQ-016 SHALL drive wb_ready = NOT rst AND (NOT buf_valid OR NOT wb_hold), combinationally.
REQ-017 SHALL capture wb_addr/wb_data into the buffer and set buf_valid at the edge where wb_valid AND wb_ready; back-to-back accepts with simultaneous commit SHALL lose no data.
REQ-018 SHALL clear buf_valid on commit when no new request is accepted in the same cycle.
REQ-019 SHALL keep buffer contents unchanged while wb_hold is high and buf_valid is high; wb_data changes during hold SHALL be ignored.
REQ-020 SHALL hardwire register 0 to 16'h0000: commits to address 0 SHALL complete handshake and clear buf_valid but SHALL not modify r0.
REQ-021 SHALL give latency: request accepted at edge N -> buffered cycle N+1 -> visible on r<k> from cycle N+2 if wb_hold low in cycle N+1.
REQ-022 SHALL drive rd_data_x = buf_data when buf_valid AND buf_addr == rd_sel_x AND rd_sel_x != 0, else register[rd_sel_x] (bypass regardless of wb_hold).
REQ-023 SHALL set busy[set_addr] at the edge where set_busy is high and set_addr != 0; set_addr 0 SHALL be ignored.
REQ-024 SHALL clear busy[buf_addr] at the edge of a commit.
REQ-025 SHALL, when set and clear target the same register at the same edge, leave the bit set (set wins).
REQ-026 SHALL keep busy[0] constantly 0.
REQ-027 SHALL have no combinational path from wb_data to r0..r7.

Reset
REQ-028 SHALL, at an edge with rst high, clear all registers to 16'h0000, buf_valid to 0 and busy to 8'h00, discarding any buffered write and any same-cycle set_busy.
REQ-029 SHALL hold wb_ready at 0 while rst is high; after rst deasserts, wb_ready SHALL be 1 in the first cycle.

Verification
REQ-030 Reset: r3=16'h1234 then rst high one cycle -> r0..r7 = 0, busy = 8'h00, wb_ready 0 during rst, 1 after.
REQ-031 Basic write: set_busy addr 5, then wb_valid addr 5 data 16'hBEEF, wb_hold 0 -> rd_data_a (sel 5) = 16'hBEEF cycle N+1, r5 = 16'hBEEF cycle N+2, busy[5] cleared at N+2.
REQ-032 Hold: buffer addr 2 data 16'h00AA, wb_hold high 3 cycles with new wb_valid 16'h00BB -> wb_ready 0, r2 unchanged, bypass shows 16'h00AA; hold drop -> r2 = 16'h00AA, then 16'h00BB accepted.
REQ-033 Back-to-back: wb_valid every cycle to addrs 1,2,3 data 16'h0011,16'h0022,16'h0033 -> wb_ready stays 1, registers hold all three values, no drop.
REQ-034 Register 0: write 16'hFFFF to addr 0, set_busy addr 0 -> r0 stays 16'h0000, busy[0] 0, wb_ready returns 1.
REQ-035 Set/clear collision: buffered commit to addr 4 and set_busy addr 4 same cycle -> busy[4] = 1 next cycle; reset asserted with buf_valid 1 -> write discarded, target register 0.
